// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data memory) in front of a shared single-port memory.
// Data requests win unless a pending fetch has already been passed over STARVE_MAX times in a row.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        bus_err
);

   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int unsigned BW = 8;

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

   state_t        state, state_d;
   logic [SW-1:0] starve_cnt, starve_cnt_d;
   logic [BW-1:0] busy_cnt, busy_cnt_d;
   logic [31:0]   cmd_addr, cmd_addr_d;
   logic [31:0]   cmd_wdata, cmd_wdata_d;
   logic          cmd_we, cmd_we_d;
   logic [3:0]    cmd_be, cmd_be_d;
   logic [31:0]   if_rdata_d, dm_rdata_d;
   logic          if_ready_d, dm_ready_d, bus_err_d, mem_en_d;
   logic [3:0]    mem_we_d;
   logic          starve_hit, timed_out;

   // Next-state, command capture and registered-output values
   always_comb begin
      state_d      = state;
      starve_cnt_d = starve_cnt;
      busy_cnt_d   = busy_cnt;
      cmd_addr_d   = cmd_addr;
      cmd_wdata_d  = cmd_wdata;
      cmd_we_d     = cmd_we;
      cmd_be_d     = cmd_be;
      if_rdata_d   = if_rdata;
      dm_rdata_d   = dm_rdata;
      if_ready_d   = 1'b0;
      dm_ready_d   = 1'b0;
      bus_err_d    = 1'b0;
      starve_hit   = if_req && (starve_cnt == SW'(STARVE_MAX));
      timed_out    = (busy_cnt == BW'(TIMEOUT - 1));

      unique case (state)
         IDLE: begin
            if (dm_req && !starve_hit) begin
               state_d     = BUSY_DM;
               busy_cnt_d  = '0;
               cmd_addr_d  = dm_addr;
               cmd_wdata_d = dm_wdata;
               cmd_we_d    = dm_we;
               cmd_be_d    = dm_be;
               if (!if_req)
                  starve_cnt_d = '0;
               else if (starve_cnt != SW'(STARVE_MAX))
                  starve_cnt_d = starve_cnt + SW'(1);
            end else if (if_req) begin
               state_d      = BUSY_IF;
               busy_cnt_d   = '0;
               cmd_addr_d   = if_addr;
               cmd_wdata_d  = '0;
               cmd_we_d     = 1'b0;
               cmd_be_d     = '0;
               starve_cnt_d = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            // An ack on the last allowed cycle still counts as a normal completion
            if (mem_ack || timed_out) begin
               state_d   = DONE;
               bus_err_d = !mem_ack;
               if (state == BUSY_IF) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_ack ? mem_rdata : '0;
               end else begin
                  dm_ready_d = 1'b1;
                  if (!mem_ack)
                     dm_rdata_d = '0;
                  else if (!cmd_we)
                     dm_rdata_d = mem_rdata;
               end
            end else begin
               busy_cnt_d = busy_cnt + BW'(1);
            end
         end
         DONE: state_d = IDLE;
      endcase

      mem_en_d = (state_d == BUSY_IF) || (state_d == BUSY_DM);
      mem_we_d = ((state_d == BUSY_DM) && cmd_we_d) ? cmd_be_d : 4'b0000;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         starve_cnt <= '0;
         busy_cnt   <= '0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_we     <= 1'b0;
         cmd_be     <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         bus_err    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= '0;
      end else begin
         state      <= state_d;
         starve_cnt <= starve_cnt_d;
         busy_cnt   <= busy_cnt_d;
         cmd_addr   <= cmd_addr_d;
         cmd_wdata  <= cmd_wdata_d;
         cmd_we     <= cmd_we_d;
         cmd_be     <= cmd_be_d;
         if_rdata   <= if_rdata_d;
         dm_rdata   <= dm_rdata_d;
         if_ready   <= if_ready_d;
         dm_ready   <= dm_ready_d;
         bus_err    <= bus_err_d;
         mem_en     <= mem_en_d;
         mem_we     <= mem_we_d;
      end
   end

   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

   // Combinational so the pipeline holds in the same cycle the request appears
   assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 255;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_be;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_en, stall, bus_err;
   logic [3:0]  mem_we;
   logic        mem_ack = 1'b0;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;

   int ack_wait = 0;
   bit ack_always = 1'b0;
   int wcnt = 0;

   // Reference model: one outstanding transaction record plus per-requester results
   bit          m_active = 1'b0, m_cool = 1'b0, m_is_dm = 1'b0, m_store = 1'b0, m_dmw = 1'b0;
   int          m_elapsed = 0, m_streak = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
   logic [3:0]  m_we = '0;
   bit          m_if_rdy = 1'b0, m_dm_rdy = 1'b0, m_err = 1'b0;

   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm, input int maxc, output bit gi, output bit gd);
      gi = 1'b0;
      gd = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick();
         if (if_ready || dm_ready) begin
            gi = if_ready;
            gd = dm_ready;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s: actual=no ready required=ready within %0d cycles", nm, maxc);
   endtask

   // Memory responder: ack after ack_wait busy cycles (negative = never)
   always @(posedge clk) begin
      #1;
      if (!rstn) begin
         mem_ack = 1'b0;
         wcnt = 0;
      end else if (mem_en) begin
         mem_ack = ack_always || (ack_wait >= 0 && wcnt == ack_wait);
         wcnt++;
      end else begin
         mem_ack = ack_always;
         wcnt = 0;
      end
   end

   // Transaction-level model of arbitration, completion, timeout and reset
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active = 1'b0; m_cool = 1'b0; m_streak = 0; m_elapsed = 0;
         m_if_rd = '0; m_dm_rd = '0;
         m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_err = 1'b0;
      end else begin
         m_if_rdy = 1'b0;
         m_dm_rdy = 1'b0;
         m_err = 1'b0;
         if (m_cool) begin
            m_cool = 1'b0;
         end else if (m_active) begin
            m_elapsed++;
            if (mem_ack || m_elapsed >= TIMEOUT) begin
               m_active = 1'b0;
               m_cool = 1'b1;
               m_err = !mem_ack;
               if (m_is_dm) begin
                  m_dm_rdy = 1'b1;
                  if (!mem_ack) m_dm_rd = '0;
                  else if (!m_store) m_dm_rd = mem_rdata;
               end else begin
                  m_if_rdy = 1'b1;
                  m_if_rd = mem_ack ? mem_rdata : '0;
               end
            end
         end else if (dm_req || if_req) begin
            m_dmw = dm_req && !(if_req && m_streak >= STARVE_MAX);
            m_active = 1'b1;
            m_elapsed = 0;
            m_is_dm = m_dmw;
            if (m_dmw) begin
               m_addr = dm_addr;
               m_wdata = dm_wdata;
               m_store = dm_we;
               m_we = dm_we ? dm_be : 4'b0000;
               m_streak = if_req ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
            end else begin
               m_addr = if_addr;
               m_store = 1'b0;
               m_we = 4'b0000;
               m_streak = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("mem_en", 32'(mem_en), 32'(m_active));
         chk("mem_we", 32'(mem_we), m_active ? 32'(m_we) : 32'd0);
         if (m_active) chk("mem_addr", mem_addr, m_addr);
         if (m_active && m_is_dm) chk("mem_wdata", mem_wdata, m_wdata);
         chk("if_ready", 32'(if_ready), 32'(m_if_rdy));
         chk("dm_ready", 32'(dm_ready), 32'(m_dm_rdy));
         chk("bus_err", 32'(bus_err), 32'(m_err));
         chk("if_rdata", if_rdata, m_if_rd);
         chk("dm_rdata", dm_rdata, m_dm_rd);
         chk("stall", 32'(stall), 32'((if_req & ~m_if_rdy) | (dm_req & ~m_dm_rdy)));
      end
   end

   initial begin
      bit gi, gd;
      int n;
      rstn = 1'b1;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'b0000;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      #3 rstn = 1'b0;
      cmp_on = 1'b1;
      repeat (2) tick();

      // Reset state
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_dm_ready", 32'(dm_ready), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      rstn = 1'b1;
      tick();

      // Zero-wait instruction fetch
      if_addr = 32'h0040_0000; mem_rdata = 32'h8C08_0004; ack_wait = 0; if_req = 1'b1;
      tick();
      chk("if0_mem_en_c1", 32'(mem_en), 32'd1);
      chk("if0_mem_addr", mem_addr, 32'h0040_0000);
      chk("if0_mem_we", 32'(mem_we), 32'd0);
      tick();
      chk("if0_ready_c2", 32'(if_ready), 32'd1);
      chk("if0_rdata", if_rdata, 32'h8C08_0004);
      chk("if0_mem_en_done", 32'(mem_en), 32'd0);
      if_req = 1'b0;
      tick();
      chk("if0_ready_c3", 32'(if_ready), 32'd0);

      // Simultaneous requests: DM store first, then IF; late input changes ignored
      dm_addr = 32'h1001_0000; dm_wdata = 32'hA5A5_1234; dm_we = 1'b1; dm_be = 4'b0011;
      if_addr = 32'h0040_0004; mem_rdata = 32'h1111_2222; ack_wait = 1;
      if_req = 1'b1; dm_req = 1'b1;
      tick();
      chk("sim_dm_mem_we", 32'(mem_we), 32'h3);
      chk("sim_dm_addr", mem_addr, 32'h1001_0000);
      dm_addr = 32'hDEAD_0000; dm_be = 4'b1111;
      tick();
      chk("sim_latched_addr", mem_addr, 32'h1001_0000);
      chk("sim_latched_we", 32'(mem_we), 32'h3);
      tick();
      chk("sim_dm_ready", 32'(dm_ready), 32'd1);
      chk("sim_store_rdata", dm_rdata, 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      wait_ready("sim_if_wait", 10, gi, gd);
      chk("sim_if_second", 32'(gi), 32'd1);
      chk("sim_if_rdata", if_rdata, 32'h1111_2222);
      if_req = 1'b0;
      tick();

      // Starvation: four DM grants, then IF, then DM again (counter cleared)
      dm_addr = 32'h1001_0040; dm_we = 1'b0; mem_rdata = 32'h0BAD_BEEF; ack_wait = 0;
      if_req = 1'b1; dm_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_ready("starve_wait", 10, gi, gd);
         chk("starve_grant_is_dm", 32'(gd), (i == 4) ? 32'd0 : 32'd1);
      end
      chk("starve_dm_rdata", dm_rdata, 32'h0BAD_BEEF);
      if_req = 1'b0; dm_req = 1'b0;
      tick();

      // Timeout: no ack ever
      ack_wait = -1; dm_req = 1'b1;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (dm_ready) break;
         if (mem_en) n++;
      end
      chk("tmo_busy_cycles", 32'(n), 32'd255);
      chk("tmo_dm_ready", 32'(dm_ready), 32'd1);
      chk("tmo_dm_rdata", dm_rdata, 32'd0);
      chk("tmo_bus_err", 32'(bus_err), 32'd1);
      dm_req = 1'b0;
      tick();
      chk("tmo_bus_err_pulse", 32'(bus_err), 32'd0);

      // Reset in the middle of a 3-wait DM read
      ack_wait = 3; dm_addr = 32'h1001_0080; dm_req = 1'b1;
      tick();
      tick();
      chk("rmid_busy", 32'(mem_en), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("rmid_async_mem_en", 32'(mem_en), 32'd0);
      chk("rmid_dm_ready", 32'(dm_ready), 32'd0);
      dm_req = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      if_addr = 32'h0040_0100; mem_rdata = 32'hCAFE_F00D; ack_wait = 0; if_req = 1'b1;
      wait_ready("rmid_resume", 10, gi, gd);
      chk("rmid_if_served", 32'(gi), 32'd1);
      chk("rmid_if_rdata", if_rdata, 32'hCAFE_F00D);
      if_req = 1'b0;
      tick();

      // Stall across a 2-wait DM read
      ack_wait = 2; dm_req = 1'b1;
      #1;
      chk("stall_req", 32'(stall), 32'd1);
      n = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dm_ready) break;
         chk("stall_busy", 32'(stall), 32'd1);
         n++;
      end
      chk("stall_cycles", 32'(n), 32'd4);
      chk("stall_at_ready", 32'(stall), 32'd0);
      dm_req = 1'b0;
      tick();
      chk("stall_idle", 32'(stall), 32'd0);

      // Stray ack while idle is ignored
      ack_always = 1'b1;
      repeat (3) tick();
      chk("stray_mem_en", 32'(mem_en), 32'd0);
      chk("stray_no_ready", 32'(if_ready | dm_ready), 32'd0);
      dm_addr = 32'h1001_0100; dm_wdata = 32'h5566_7788; dm_we = 1'b1; dm_be = 4'b1100;
      dm_req = 1'b1;
      tick();
      chk("stray_mem_we", 32'(mem_we), 32'hC);
      tick();
      chk("stray_dm_ready", 32'(dm_ready), 32'd1);
      dm_req = 1'b0; dm_we = 1'b0; ack_always = 1'b0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
